// File: rtl/spi_pkg.sv
// spi_pkg: SPI constants and FSM state encoding shared by SPI master and slave
package spi_pkg;
  localparam int SPI_WIDTH = 8;
  localparam int CNT_W = $clog2(SPI_WIDTH);
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} spi_state_e;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer with registered rise/fall pulses, pulses held off until the chain is filled after reset
module spi_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] vld_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{RST_VAL}};
      vld_q  <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      vld_q  <= {vld_q[STAGES-2:0], 1'b1};
      rise_o <= vld_q[STAGES-1] & sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall_o <= vld_q[STAGES-1] & ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end
  end
endmodule

// File: rtl/spi_slave_driver.sv
// spi_slave_driver: SPI mode-0 MSB-first byte slave with a clk_i-domain load/receive interface
module spi_slave_driver
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [SPI_WIDTH-1:0] data_in_bi,
  output logic                 tx_load_o,
  output logic [SPI_WIDTH-1:0] data_out_bo,
  output logic                 rx_valid_o,
  output logic                 busy_o,
  input  logic                 spi_sclk_i,
  input  logic                 spi_cs_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o
);
  spi_state_e state_q, state_d;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic start, stop, shift_in, shift_out, byte_done;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SPI_WIDTH-1:0] tx_q;
  logic [SPI_WIDTH-2:0] rx_q;
  logic [CNT_W-1:0] cnt_q;
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk_i, .rst_n_i, .d_i(spi_sclk_i), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_i, .rst_n_i, .d_i(spi_cs_i), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  always_comb begin
    start     = state_q == IDLE && cs_fall;
    stop      = state_q == ACTIVE && cs_rise;
    shift_in  = state_q == ACTIVE && !cs_rise && sclk_rise;
    shift_out = state_q == ACTIVE && !cs_rise && sclk_fall;
    byte_done = shift_in && cnt_q == CNT_W'(SPI_WIDTH - 1);
    state_d   = start ? ACTIVE : stop ? IDLE : state_q;
    tx_load_o = start || (shift_out && cnt_q == '0);
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mosi_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      data_out_bo <= '0;
      rx_valid_o  <= 1'b0;
    end else begin
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
      rx_valid_o <= byte_done;
      if (tx_load_o) tx_q <= data_in_bi;
      else if (shift_out) tx_q <= tx_q << 1;
      if (start || stop) cnt_q <= '0;
      else if (shift_in) cnt_q <= cnt_q + CNT_W'(1);
      if (shift_in) rx_q <= {rx_q[SPI_WIDTH-3:0], mosi_q[SYNC_STAGES-1]};
      if (byte_done) data_out_bo <= {rx_q, mosi_q[SYNC_STAGES-1]};
    end
  end
  assign busy_o     = state_q == ACTIVE;
  assign spi_miso_o = busy_o & tx_q[SPI_WIDTH-1];
endmodule

// File: doc/spi_slave_driver.md
SPI_SLAVE_DRIVER -- requirements
Module: spi_slave_driver

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each SPI input; legal values are 2 and 3.
REQ-002 Port clk_i, input, 1: system clock, the only clock.
REQ-003 Port rst_n_i, input, 1: asynchronous reset, active-low.
REQ-004 Port data_in_bi, input, 8: byte the slave returns on MISO in the next byte slot.
REQ-005 Port tx_load_o, output, 1: one-cycle pulse; data_in_bi was sampled this cycle.
REQ-006 Port data_out_bo, output, 8: last complete byte received on MOSI.
REQ-007 Port rx_valid_o, output, 1: one-cycle pulse; data_out_bo was updated this cycle.
REQ-008 Port busy_o, output, 1: high while chip select is active (synchronized).
REQ-009 Port spi_sclk_i, input, 1: SPI clock from master, asynchronous to clk_i.
REQ-010 Port spi_cs_i, input, 1: chip select, active-low, asynchronous.
REQ-011 Port spi_mosi_i, input, 1: master-out data, asynchronous.
REQ-012 Port spi_miso_o, output, 1: slave-out data; driven 0 when not selected.

Function
REQ-013 The block SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
REQ-014 spi_sclk_i, spi_cs_i and spi_mosi_i SHALL each pass through SYNC_STAGES flops; all logic SHALL use only synchronized copies and edges derived from them.
REQ-015 Supported SCLK frequency SHALL be at most clk_i/8; behaviour above this is undefined.
REQ-016 The FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on synchronized CS falling edge; ACTIVE->IDLE on synchronized CS rising edge.
REQ-017 On IDLE->ACTIVE, the block SHALL load data_in_bi into the tx shift register, pulse tx_load_o, and clear the 3-bit bit counter in that same cycle.
REQ-018 spi_miso_o SHALL equal tx shift register bit 7 while ACTIVE, and 0 while IDLE.
REQ-019 On each synchronized SCLK rising edge in ACTIVE, the block SHALL shift synchronized MOSI into the rx shift register LSB and increment the bit counter modulo 8.
REQ-020 On each synchronized SCLK falling edge in ACTIVE, the block SHALL left-shift the tx register, except when the bit counter is 0 after a completed byte (REQ-021).
REQ-021 When the 8th rising edge of a byte is detected, data_out_bo SHALL take the completed byte and rx_valid_o SHALL pulse on the next clk_i cycle.
REQ-022 On the falling edge following a completed byte while CS stays low, the block SHALL reload data_in_bi, pulse tx_load_o, and continue without gaps (multi-byte transfers).
REQ-023 A CS rising edge mid-byte SHALL discard the partial byte: no rx_valid_o, data_out_bo unchanged, counter cleared.
REQ-024 A simultaneous CS rising edge and SCLK edge SHALL be resolved in favour of CS (edge ignored).
REQ-025 SCLK edges while IDLE SHALL be ignored.
REQ-026 busy_o SHALL equal (state == ACTIVE).

Reset
REQ-027 While rst_n_i is low, state=IDLE, shift registers, counter and data_out_bo SHALL be 0; tx_load_o, rx_valid_o, busy_o and spi_miso_o SHALL be 0.
REQ-028 Synchronizer flops SHALL reset to the idle line levels: SCLK 0, CS 1, MOSI 0.
REQ-029 A reset asserted mid-transfer SHALL abort it; after release, the block SHALL wait for a fresh CS falling edge.

Structure
REQ-030 Shared package spi_pkg SHALL hold SPI_WIDTH=8 and the FSM state encoding, shared with the SPI master.
REQ-031 One sub-module spi_sync SHALL implement the SYNC_STAGES synchronizer with registered rise/fall pulses, instantiated for SCLK and CS; MOSI uses level only.

Verification
REQ-032 Master sends 0xA5 and data_in_bi=0x3C -> one rx_valid_o pulse with data_out_bo=0xA5; the master receives 0x3C.
REQ-033 CS held low for 0x12,0x34 with data_in_bi changed to 0x56 then 0x78 at the tx_load_o pulses -> rx_valid_o pulses twice (0x12, 0x34); the master receives 0x56, 0x78.
REQ-034 CS raised after 3 SCLK cycles -> no rx_valid_o; data_out_bo keeps its prior value; busy_o falls; spi_miso_o=0.
REQ-035 rst_n_i pulsed low after bit 4 of 0xFF -> all outputs 0 immediately; the next full 0x81 transfer is received correctly.
REQ-036 SCLK toggled 8 times with CS high -> no rx_valid_o or tx_load_o; spi_miso_o stays 0.
